// File: rtl/stage3_execute_mc_if.sv
// Execute-stage bundle: decoded operation from stage 2, results and controls to stage 4.
// master drives the *_i fields and stall_i; slave is the execute stage.
interface stage3_execute_mc_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
);
   logic              stall_i;
   logic              stall_o;
   logic [1:0]        control_branch_i;
   logic              control_load_i;
   logic              control_store_i;
   logic              mul_i;
   logic [3:0]        aluop_i;
   logic [DATA_W-1:0] alu_a_i;
   logic [DATA_W-1:0] alu_b_i;
   logic [DATA_W-1:0] branch_test_val_i;
   logic              do_wb_i;
   logic [REG_W-1:0]  wb_reg_i;
   logic [DATA_W-1:0] alu_o;
   logic              control_load_o;
   logic              control_store_o;
   logic              control_take_branch_o;
   logic              do_wb_o;
   logic [REG_W-1:0]  wb_reg_o;

   modport master (
      output stall_i, control_branch_i, control_load_i, control_store_i, mul_i, aluop_i,
             alu_a_i, alu_b_i, branch_test_val_i, do_wb_i, wb_reg_i,
      input  stall_o, alu_o, control_load_o, control_store_o, control_take_branch_o,
             do_wb_o, wb_reg_o
   );

   modport slave (
      input  stall_i, control_branch_i, control_load_i, control_store_i, mul_i, aluop_i,
             alu_a_i, alu_b_i, branch_test_val_i, do_wb_i, wb_reg_i,
      output stall_o, alu_o, control_load_o, control_store_o, control_take_branch_o,
             do_wb_o, wb_reg_o
   );
endinterface

// File: rtl/stage3_execute_mc.sv
// Execute stage: registered operands, single-cycle ALU, DATA_W-cycle shift-add multiplier.
// Latency 1 for ALU ops, DATA_W+1 edges for multiplies; stalls upstream while multiplying.
module stage3_execute_mc #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4,
   parameter int CNT_W  = 6
) (
   input logic               clk_i,
   input logic               rst_i,
   stage3_execute_mc_if.slave bus
);
   localparam int SH_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t            state_q, state_d;
   logic [1:0]        branch_q;
   logic              load_q, store_q, mul_q, do_wb_q;
   logic [3:0]        aluop_q;
   logic [DATA_W-1:0] a_q, b_q, test_q;
   logic [REG_W-1:0]  wb_reg_q;
   logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] alu_res;
   logic              capture, in_mul, take;

   assign in_mul      = (state_q == S_MUL);
   assign bus.stall_o = bus.stall_i | in_mul;
   assign capture     = ~bus.stall_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         branch_q <= '0;
         load_q   <= 1'b0;
         store_q  <= 1'b0;
         mul_q    <= 1'b0;
         do_wb_q  <= 1'b0;
         aluop_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         test_q   <= '0;
         wb_reg_q <= '0;
      end else if (capture) begin
         branch_q <= bus.control_branch_i;
         load_q   <= bus.control_load_i;
         store_q  <= bus.control_store_i;
         mul_q    <= bus.mul_i;
         do_wb_q  <= bus.do_wb_i;
         aluop_q  <= bus.aluop_i;
         a_q      <= bus.alu_a_i;
         b_q      <= bus.alu_b_i;
         test_q   <= bus.branch_test_val_i;
         wb_reg_q <= bus.wb_reg_i;
      end
   end

   // One shift-add step per edge; stall_i does not pause iteration.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (in_mul) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end else if (capture && bus.mul_i) begin
         mcand_q  <= bus.alu_a_i;
         mplier_q <= bus.alu_b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (capture && bus.mul_i) state_d = S_MUL;
         S_MUL:   if (cnt_q == LAST_CNT) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (aluop_q)
         4'd0:    alu_res = a_q + b_q;
         4'd1:    alu_res = a_q - b_q;
         4'd2:    alu_res = a_q & b_q;
         4'd3:    alu_res = a_q | b_q;
         4'd4:    alu_res = a_q ^ b_q;
         4'd5:    alu_res = a_q << b_q[SH_W-1:0];
         4'd6:    alu_res = a_q >> b_q[SH_W-1:0];
         4'd7:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'd8:    alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
         default: alu_res = b_q;
      endcase
   end

   always_comb begin
      take = 1'b0;
      case (branch_q)
         2'd0: take = 1'b0;
         2'd1: take = 1'b1;
         2'd2: take = (test_q != '0);
         2'd3: take = (test_q == '0);
         default: take = 1'b0;
      endcase
   end

   // Controls are bubbled while multiplying; wb_reg_o keeps the held index.
   assign bus.alu_o                 = mul_q ? acc_q : alu_res;
   assign bus.control_load_o        = load_q  & ~in_mul;
   assign bus.control_store_o       = store_q & ~in_mul;
   assign bus.control_take_branch_o = take    & ~in_mul;
   assign bus.do_wb_o               = do_wb_q & ~in_mul;
   assign bus.wb_reg_o              = wb_reg_q;
endmodule

// File: tb/tb_stage3_execute_mc.sv
// Scoreboard bench for stage3_execute_mc: driver pushes expected results, monitor checks.
module tb_stage3_execute_mc;
   localparam int DATA_W = 32;
   localparam int REG_W  = 4;
   localparam int CNT_W  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stage3_execute_mc_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

   stage3_execute_mc #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic        mul;
      logic [31:0] alu;
      logic        ld;
      logic        st;
      logic        tk;
      logic        wb;
      logic [3:0]  wreg;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [1:0]  n_br;
   logic        n_ld, n_st, n_mul, n_wb, captured;
   logic [3:0]  n_op, n_reg;
   logic [31:0] n_a, n_b, n_tv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:    return (a < b) ? 32'd1 : 32'd0;
         default: return b;
      endcase
   endfunction

   function automatic exp_t model();
      exp_t e;
      logic [63:0] prod;
      prod   = {32'd0, n_a} * {32'd0, n_b};
      e.mul  = n_mul;
      e.alu  = n_mul ? prod[31:0] : ref_alu(n_op, n_a, n_b);
      e.ld   = n_ld;
      e.st   = n_st;
      e.wb   = n_wb;
      e.wreg = n_reg;
      case (n_br)
         2'd0:    e.tk = 1'b0;
         2'd1:    e.tk = 1'b1;
         2'd2:    e.tk = (n_tv != 0);
         default: e.tk = (n_tv == 0);
      endcase
      return e;
   endfunction

   task automatic set_op(input logic [1:0] br, input logic ld, input logic st, input logic mul,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] tv, input logic wb, input logic [3:0] wreg);
      n_br = br; n_ld = ld; n_st = st; n_mul = mul; n_op = op;
      n_a = a; n_b = b; n_tv = tv; n_wb = wb; n_reg = wreg;
   endtask

   task automatic rand_op(input int mul_pct);
      n_br  = 2'($urandom_range(0, 3));
      n_ld  = 1'($urandom_range(0, 1));
      n_st  = 1'($urandom_range(0, 1));
      n_mul = ($urandom_range(0, 99) < mul_pct);
      n_op  = 4'($urandom_range(0, 15));
      n_a   = $urandom;
      n_b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      n_tv  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      n_wb  = 1'($urandom_range(0, 1));
      n_reg = 4'($urandom_range(0, 15));
   endtask

   task automatic step(input logic st);
      @(negedge clk);
      bus.stall_i           = st;
      bus.control_branch_i  = n_br;
      bus.control_load_i    = n_ld;
      bus.control_store_i   = n_st;
      bus.mul_i             = n_mul;
      bus.aluop_i           = n_op;
      bus.alu_a_i           = n_a;
      bus.alu_b_i           = n_b;
      bus.branch_test_val_i = n_tv;
      bus.do_wb_i           = n_wb;
      bus.wb_reg_i          = n_reg;
      #1;
      captured = !rst && !bus.stall_o;
      if (captured) q.push_back(model());
   endtask

   task automatic issue();
      int n;
      n = 0;
      do begin
         step(1'b0);
         n++;
      end while (!captured && n < 100);
      if (!captured) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: no capture within %0d cycles", n);
      end
   endtask

   task automatic do_reset_mid();
      @(posedge clk);
      #2;
      rst = 1'b1;
      bus.stall_i = 1'b1;
      q.delete();
      #1;
      chk("rst_async_alu", bus.alu_o, 0);
      chk("rst_async_wb", bus.do_wb_o, 0);
      chk("rst_async_ld", bus.control_load_o, 0);
      chk("rst_async_st", bus.control_store_o, 0);
      chk("rst_async_tk", bus.control_take_branch_o, 0);
      chk("rst_async_reg", bus.wb_reg_o, 0);
      chk("rst_async_stall", bus.stall_o, bus.stall_i);
      @(negedge clk);
      #3;
      rst = 1'b0;
   endtask

   // Monitor state
   int   mul_left = 0;
   bit   res_due  = 0;
   bit   pend     = 0;
   bit   handled  = 0;
   exp_t cur, last;

   task automatic cmp_out(input string tag, input exp_t e);
      chk({tag, "_alu"}, bus.alu_o, e.alu);
      chk({tag, "_ld"}, bus.control_load_o, e.ld);
      chk({tag, "_st"}, bus.control_store_o, e.st);
      chk({tag, "_tk"}, bus.control_take_branch_o, e.tk);
      chk({tag, "_wb"}, bus.do_wb_o, e.wb);
      chk({tag, "_reg"}, bus.wb_reg_o, e.wreg);
   endtask

   initial begin
      last = '0;
      cur  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            mul_left = 0;
            res_due  = 0;
            pend     = 0;
            last     = '0;
            cmp_out("reset", last);
         end else begin
            handled = 0;
            if (pend) begin
               handled = 1;
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard_underflow: capture with empty queue");
               end else begin
                  cur = q.pop_front();
                  if (cur.mul) begin
                     mul_left = DATA_W;
                  end else begin
                     cmp_out("op", cur);
                     last = cur;
                  end
               end
            end
            if (mul_left > 0) begin
               chk("mul_stall_o", bus.stall_o, 1);
               chk("mul_bubble_wb", bus.do_wb_o, 0);
               chk("mul_bubble_ld", bus.control_load_o, 0);
               chk("mul_bubble_st", bus.control_store_o, 0);
               chk("mul_bubble_tk", bus.control_take_branch_o, 0);
               chk("mul_hold_reg", bus.wb_reg_o, cur.wreg);
               mul_left--;
               if (mul_left == 0) res_due = 1;
            end else begin
               if (res_due) begin
                  cmp_out("mul_result", cur);
                  last    = cur;
                  res_due = 0;
               end else if (!handled) begin
                  cmp_out("hold", last);
               end
               chk("idle_stall_o", bus.stall_o, bus.stall_i);
            end
            pend = !bus.stall_o;
         end
      end
   end

   initial begin
      set_op(2'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0);
      bus.stall_i = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      rst = 1'b0;

      do_reset_mid();
      set_op(2'd0, 0, 0, 0, 4'd0, 32'd5, 32'd7, 32'd1, 1, 4'd3);
      issue();

      set_op(2'd0, 0, 0, 1, 4'd5, 32'd7, 32'd6, 32'd0, 1, 4'd9);
      issue();
      set_op(2'd2, 1, 0, 1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 1, 4'd2);
      issue();

      set_op(2'd3, 0, 0, 0, 4'd2, 32'd1, 32'd2, 32'd0, 0, 4'd1);
      issue();
      set_op(2'd2, 0, 0, 0, 4'd3, 32'd1, 32'd2, 32'd0, 0, 4'd1);
      issue();
      set_op(2'd2, 0, 0, 0, 4'd4, 32'd1, 32'd2, 32'h8000_0000, 0, 4'd1);
      issue();
      set_op(2'd1, 0, 0, 0, 4'd1, 32'd9, 32'd2, 32'd0, 0, 4'd1);
      issue();
      set_op(2'd0, 0, 0, 0, 4'd7, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 4'd1);
      issue();

      set_op(2'd1, 1, 0, 0, 4'd0, 32'd100, 32'd23, 32'd0, 1, 4'd7);
      issue();
      repeat (3) begin
         rand_op(50);
         step(1'b1);
      end

      set_op(2'd0, 0, 0, 1, 4'd0, 32'h0001_2345, 32'h0000_0ABC, 32'd0, 1, 4'd11);
      issue();
      repeat (40) begin
         rand_op(50);
         step(1'b1);
      end

      set_op(2'd0, 0, 0, 1, 4'd0, 32'd123, 32'd456, 32'd0, 1, 4'd4);
      issue();
      repeat (9) begin
         rand_op(50);
         step(1'b0);
      end
      do_reset_mid();
      set_op(2'd0, 0, 0, 1, 4'd0, 32'd3, 32'd4, 32'd0, 1, 4'd5);
      issue();
      set_op(2'd0, 0, 0, 1, 4'd0, 32'd10, 32'd11, 32'd0, 1, 4'd6);
      issue();

      set_op(2'd0, 0, 1, 0, 4'd0, 32'd8, 32'd8, 32'd0, 0, 4'd12);
      issue();

      repeat (600) begin
         rand_op(8);
         step($urandom_range(0, 3) == 0);
      end

      repeat (DATA_W + 5) step(1'b1);
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
